// File: rtl/mac_seq_ctrl_if.sv
// Purpose : groups the mac_seq_ctrl request, read-issue and write-back signals into one bundle.
// Ports   : master = layer-control side (drives start/len/hold, observes the rest);
//           slave  = sequencer side (samples start/len/hold, drives read/MAC/write strobes).
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 4
);
  // request from layer control
  logic              start;
  logic [ADDR_W:0]   len;
  logic              hold;
  // input-buffer read issue
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  // MAC strobes
  logic              mac_en;
  logic              mac_lastdata;
  // output-buffer write-back and status
  logic              wr_en;
  logic [OUT_W-1:0]  wr_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, len, hold,
    input  rd_en, rd_addr, mac_en, mac_lastdata, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  start, len, hold,
    output rd_en, rd_addr, mac_en, mac_lastdata, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Purpose     : sequences one dot-product vector from the ifmap/weight buffers through one MAC.
// Latency     : start to done = len + 2 cycles, plus one cycle per hold cycle spent in ISSUE.
// Backpressure: hold stalls read issue only; beats already in flight still reach the MAC.
// Ports: clk, reset (synchronous, active-high); ctl (slave modport) carries start/len/hold in,
//        rd_en/rd_addr to both buffers, mac_en/mac_lastdata to the MAC, wr_en/wr_addr/busy/done out.
module mac_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 4
) (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.slave  ctl
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  // len and the read counter carry one extra bit so a full 2^ADDR_W vector is representable
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              mac_en_q, mac_en_d;
  logic              last_q, last_d;
  logic              wr_en_q, wr_en_d;
  logic [OUT_W-1:0]  wr_addr_q, wr_addr_d;

  logic              rd_en;
  logic              last_beat;

  // the beat currently addressed is the final one of the vector
  assign last_beat = (cnt_q == (len_q - (ADDR_W+1)'(1)));

  // ---------------------------------------------------------------------------
  // state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      mac_en_q  <= 1'b0;
      last_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      mac_en_q  <= mac_en_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // next-state and read-issue logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;

    case (state_q)
      IDLE: begin
        // a zero-length request is dropped entirely, leaving len/count untouched
        if (ctl.start && (ctl.len != '0)) begin
          len_d   = ctl.len;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (!ctl.hold) begin
          rd_en = 1'b1;
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          if (last_beat) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        // wr_en_q marks the cycle the MAC accumulation holds the final sum
        if (wr_en_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // strobe pipeline aligned to the 1-cycle buffer read and the registered MAC
  // ---------------------------------------------------------------------------
  always_comb begin
    mac_en_d  = rd_en;                       // data returns one cycle after the read
    last_d    = rd_en & last_beat;
    wr_en_d   = mac_en_q & last_q;           // accumulation registers on the last beat
    wr_addr_d = wr_addr_q;
    if (wr_en_q) begin
      wr_addr_d = wr_addr_q + OUT_W'(1);     // natural wrap at 2^OUT_W
    end
  end

  // ---------------------------------------------------------------------------
  // outputs
  // ---------------------------------------------------------------------------
  assign ctl.rd_en        = rd_en;
  assign ctl.rd_addr      = cnt_q[ADDR_W-1:0];
  assign ctl.mac_en       = mac_en_q;
  assign ctl.mac_lastdata = last_q;
  assign ctl.wr_en        = wr_en_q;
  assign ctl.wr_addr      = wr_addr_q;
  assign ctl.busy         = (state_q != IDLE);
  assign ctl.done         = wr_en_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Purpose : self-checking bench for mac_seq_ctrl with a behavioural MAC and two sync-read buffers.
// Ports   : drives the master side of mac_seq_ctrl_if; clk/reset generated locally.
// Results : scoreboard queues hold expected read addresses and expected write-backs.
module tb_mac_seq_ctrl;

  localparam int ADDR_W = 4;
  localparam int OUT_W  = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NWR    = 1 << OUT_W;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   done_cnt;
  int   exp_waddr;

  mac_seq_ctrl_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus_if ();

  mac_seq_ctrl #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- buffers + MAC model ----------------
  logic [7:0]  ifm [DEPTH];
  logic [7:0]  wgt [DEPTH];
  logic [7:0]  a_q, b_q;
  logic [19:0] psum, acc;

  always @(posedge clk) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      psum <= '0;
      acc  <= '0;
    end else begin
      if (bus_if.rd_en) begin
        a_q <= ifm[bus_if.rd_addr];
        b_q <= wgt[bus_if.rd_addr];
      end
      if (bus_if.mac_en) begin
        if (bus_if.mac_lastdata) begin
          acc  <= psum + 20'(a_q) * 20'(b_q);
          psum <= '0;
        end else begin
          psum <= psum + 20'(a_q) * 20'(b_q);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [19:0] acc;
    int          waddr;
    int          dcyc;
  } res_t;

  int   exp_rd  [$];
  res_t exp_res [$];

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    res_t r;
    if (bus_if.rd_en === 1'b1) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else                    chk("rd_addr", 32'(bus_if.rd_addr), exp_rd.pop_front());
    end
    if (bus_if.mac_lastdata === 1'b1) chk("last_with_en", 32'(bus_if.mac_en), 1);
    if ((bus_if.wr_en === 1'b1) || (bus_if.done === 1'b1)) begin
      done_cnt++;
      chk("done_hi", 32'(bus_if.done), 1);
      chk("wr_en_hi", 32'(bus_if.wr_en), 1);
      chk("busy_at_done", 32'(bus_if.busy), 1);
      if (exp_res.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        r = exp_res.pop_front();
        chk("acc", 32'(acc), 32'(r.acc));
        chk("wr_addr", 32'(bus_if.wr_addr), r.waddr);
        chk("done_cycle", cyc, r.dcyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.hold  = 1'b0;
    bus_if.len   = '0;
    repeat (3) @(posedge clk);
    #1;
    exp_rd.delete();
    exp_res.delete();
    exp_waddr = 0;
    reset = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},   32'(bus_if.rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus_if.rd_addr), 0);
    chk({tag, "_mac_en"},  32'(bus_if.mac_en), 0);
    chk({tag, "_last"},    32'(bus_if.mac_lastdata), 0);
    chk({tag, "_wr_en"},   32'(bus_if.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus_if.wr_addr), 0);
    chk({tag, "_busy"},    32'(bus_if.busy), 0);
    chk({tag, "_done"},    32'(bus_if.done), 0);
  endtask

  // run one vector starting this cycle; hold is high on relative cycles [hs, hs+hn)
  task automatic run_vec(input int n, input int hs, input int hn, input bit spam);
    logic [19:0] dot;
    int d0, w0;
    dot = '0;
    for (int i = 0; i < n; i++) begin
      dot = dot + 20'(ifm[i]) * 20'(wgt[i]);
      exp_rd.push_back(i);
    end
    exp_res.push_back('{acc: dot, waddr: exp_waddr, dcyc: cyc + n + 2 + hn});
    w0        = exp_waddr;
    exp_waddr = (exp_waddr + 1) % NWR;
    d0        = done_cnt;
    bus_if.start = 1'b1;
    bus_if.len   = (ADDR_W+1)'(n);
    for (int k = 1; k < 200; k++) begin
      step();
      if (done_cnt != d0) break;
      bus_if.start = spam;
      bus_if.hold  = (k >= hs) && (k < hs + hn);
    end
    bus_if.start = 1'b0;
    bus_if.hold  = 1'b0;
    chk("done_count", done_cnt - d0, 1);
    chk("busy_after", 32'(bus_if.busy), 0);
    chk("wr_addr_next", 32'(bus_if.wr_addr), (w0 + 1) % NWR);
  endtask

  task automatic load(input int n, input logic [7:0] base_a, input logic [7:0] base_b);
    for (int i = 0; i < n; i++) begin
      ifm[i] = base_a + 8'(i);
      wgt[i] = base_b + 8'(i);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    total = 0;
    bad = 0;
    done_cnt = 0;
    exp_waddr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ifm[i] = '0;
      wgt[i] = '0;
    end

    // reset state: outputs observed while reset is still asserted
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.hold  = 1'b0;
    bus_if.len   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // basic vector {1,2,3}.{4,5,6} = 32
    load(3, 8'd1, 8'd4);
    run_vec(3, 0, 0, 1'b0);

    // length 1: 7*3 = 21
    ifm[0] = 8'd7;
    wgt[0] = 8'd3;
    run_vec(1, 0, 0, 1'b0);

    // length 0 is ignored
    bus_if.start = 1'b1;
    bus_if.len   = '0;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      step();
      bus_if.start = 1'b0;
      chk("len0_busy",  32'(bus_if.busy), 0);
      chk("len0_rd_en", 32'(bus_if.rd_en), 0);
      chk("len0_done",  32'(bus_if.done), 0);
    end
    chk("len0_no_done", done_cnt - d0, 0);

    // hold for 2 cycles after the second read
    load(4, 8'd10, 8'd20);
    run_vec(4, 3, 2, 1'b0);

    // hold on the cycle that would issue the last beat
    load(3, 8'd2, 8'd9);
    run_vec(3, 3, 1, 1'b0);

    // start pulsed every cycle while busy: exactly one run, nothing queued
    load(3, 8'd5, 8'd6);
    d0 = done_cnt;
    run_vec(3, 0, 0, 1'b1);
    step();
    step();
    chk("spam_idle", 32'(bus_if.busy), 0);
    chk("spam_one_done", done_cnt - d0, 1);

    // reset mid-vector (cycle 2 of a len=4 run)
    load(4, 8'd50, 8'd60);
    exp_rd.push_back(0);
    exp_rd.push_back(1);
    bus_if.start = 1'b1;
    bus_if.len   = 5'd4;
    step();
    bus_if.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_waddr = 0;
    chk_all_zero("midrst");
    chk("midrst_rd_left", exp_rd.size(), 0);
    step();
    // follow-up {1,1}.{1,1} = 2 with no residue
    ifm[0] = 8'd1; ifm[1] = 8'd1;
    wgt[0] = 8'd1; wgt[1] = 8'd1;
    run_vec(2, 0, 0, 1'b0);

    // 17 back-to-back full-length vectors: wr_addr 0..15 then 0
    do_reset();
    for (int v = 0; v < 17; v++) begin
      for (int i = 0; i < DEPTH; i++) begin
        ifm[i] = 8'($urandom_range(0, 255));
        wgt[i] = 8'($urandom_range(0, 255));
      end
      run_vec(DEPTH, 0, 0, 1'b0);
    end

    step();
    step();
    chk("end_rd_left", exp_rd.size(), 0);
    chk("end_res_left", exp_res.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
